// File: rtl/intc_ctrl.sv
// intc_ctrl: priority interrupt controller with pending/mask/edge registers and ack/EOI handshake
// Optional macro INTC_PREEMPT_EN: a lower-index source may replace int_id while waiting for the ack.
module intc_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:2]      addr,
    input  logic            we,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_in,
    input  logic            int_ack,
    output logic            irq,
    output logic [2:0]      int_id
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARB = 2'b01, REQ = 2'b10, SRV = 2'b11} state_t;

    state_t          state, state_nx;
    logic [NSRC-1:0] pending, mask, edge_mask, irq_prev, act, clr;
    logic [2:0]      lo, id_nx;
    logic            eoi;
    logic            unused_din;

    assign unused_din = ^Din[31:NSRC];
    assign act        = pending & mask;
    assign eoi        = we && addr == 2'd2 && state == SRV;
    assign clr        = (we && addr == 2'd0 ? Din[NSRC-1:0] : '0) |
                        (eoi && edge_mask[int_id] ? NSRC'(1) << int_id : '0);
    assign Dout       = addr == 2'd0 ? 32'(pending) :
                        addr == 2'd1 ? 32'(mask) :
                        addr == 2'd2 ? {22'b0, state, 5'b0, int_id} : 32'(edge_mask);

    // lowest-index enabled pending source wins
    always_comb begin
        lo = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (act[i]) lo = 3'(i);
    end

    // handshake sequencing: arbitrate, request, wait for ack, wait for EOI
    always_comb begin
        state_nx = state;
        id_nx    = int_id;
        case (state)
            IDLE: if (|act) state_nx = ARB;
            ARB: begin
                state_nx = |act ? REQ : IDLE;
                if (|act) id_nx = lo;
            end
            REQ:
                if (int_ack) state_nx = SRV;
`ifdef INTC_PREEMPT_EN
                else if (|act && lo < int_id) id_nx = lo;
`endif
                else if (!act[int_id]) state_nx = IDLE;
            SRV: if (eoi) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, outputs, software registers and request latching
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            irq       <= 1'b0;
            int_id    <= 3'd0;
            pending   <= '0;
            mask      <= '0;
            edge_mask <= '1;
            irq_prev  <= '0;
        end else begin
            state     <= state_nx;
            irq       <= state_nx == REQ;
            int_id    <= id_nx;
            irq_prev  <= irq_in;
            pending   <= (edge_mask & ((pending & ~clr) | (irq_in & ~irq_prev))) | (~edge_mask & irq_in);
            if (we && addr == 2'd1) mask <= Din[NSRC-1:0];
            if (we && addr == 2'd3) edge_mask <= Din[NSRC-1:0];
        end
    end
endmodule

// File: tb/tb_intc_ctrl.sv
// tb_intc_ctrl: scoreboard bench for intc_ctrl; expected service order derived from priority rules
module tb_intc_ctrl;
    logic        clk = 0, reset = 0, we = 0, int_ack = 0, irq, irq_d = 0, rd_v = 0;
    logic [3:2]  addr = 0;
    logic [31:0] Din = 0, Dout;
    logic [5:0]  irq_in = 0;
    logic [2:0]  int_id;
    int          checks = 0, failures = 0;
    int          id_q[$];
    typedef struct {string nm; logic [31:0] exp;} rd_t;
    rd_t         rd_q[$];
    rd_t         r;

    intc_ctrl #(.NSRC(6)) dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .Din(Din), .Dout(Dout),
                               .irq_in(irq_in), .int_ack(int_ack), .irq(irq), .int_id(int_id));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // request monitor: every rising irq must match the next expected source
    always @(negedge clk) begin
        if (irq === 1'b1 && irq_d === 1'b0) begin
            if (id_q.size() == 0) chk("irq_unexpected", 32'(irq), 32'd0);
            else chk("irq_id", 32'(int_id), 32'(id_q.pop_front()));
        end
        irq_d = irq;
    end

    // read monitor: compare Dout for every read the stimulus issues
    always @(negedge clk) begin
        if (rd_v && rd_q.size() != 0) begin
            r = rd_q.pop_front();
            chk(r.nm, Dout, r.exp);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; Din = d; we = 1; tick(); we = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        addr = a; rd_q.push_back('{nm, exp}); rd_v = 1; tick(); rd_v = 0;
    endtask

    task automatic ack();
        int_ack = 1; tick(); int_ack = 0;
    endtask

    task automatic wait_irq(input logic lv);
        int n = 0;
        while (irq !== lv && n < 50) begin tick(); n++; end
        chk("wait_irq", 32'(irq), 32'(lv));
    endtask

    initial begin
        logic [5:0] m, s;
        tick(3);
        reset = 1;
        tick();
        chk("rst_irq", 32'(irq), 0);
        rd(0, 0, "rst_pending");
        rd(1, 0, "rst_mask");
        rd(2, 0, "rst_status");
        rd(3, 32'h3F, "rst_edge");

        // edge latch, latency and handshake
        wr(1, 32'h3F);
        id_q.push_back(2);
        irq_in = 6'h04; tick(); irq_in = 0;
        chk("lat_e0", 32'(irq), 0);
        tick(); chk("lat_e1", 32'(irq), 0);
        tick(); chk("lat_e2", 32'(irq), 1); chk("lat_id", 32'(int_id), 2);
        ack();
        chk("ack_irq", 32'(irq), 0);
        rd(2, 32'h302, "srv_status");
        wr(2, 0);
        rd(0, 0, "eoi_pending");
        rd(2, 32'h002, "eoi_status");

        // priority
        id_q.push_back(1); id_q.push_back(4);
        irq_in = 6'h12; tick(); irq_in = 0;
        wait_irq(1); ack(); wr(2, 0);
        wait_irq(1); ack(); wr(2, 0);
        rd(0, 0, "prio_pending");

        // masking and withdrawal
        wr(1, 0);
        irq_in = 6'h01; tick(); irq_in = 0;
        tick(3);
        chk("masked_irq", 32'(irq), 0);
        rd(0, 1, "masked_pending");
        id_q.push_back(0);
        wr(1, 1);
        tick(); chk("unmask_e1", 32'(irq), 0);
        tick(); chk("unmask_e2", 32'(irq), 1);
        wr(0, 1);
        tick(); chk("withdraw_irq", 32'(irq), 0);
        rd(2, 0, "withdraw_status");

        // level source
        wr(3, 32'h3E); wr(1, 32'h3F);
        id_q.push_back(0);
        irq_in = 6'h01;
        wait_irq(1); ack(); wr(2, 0);
        id_q.push_back(0);
        wait_irq(1); ack(); wr(2, 0);
        irq_in = 0;
        tick();
        rd(0, 0, "level_drop_pending");
        tick(3);
        chk("level_drop_irq", 32'(irq), 0);
        wr(3, 32'h3F);

        // reset mid-handshake
        id_q.push_back(5);
        irq_in = 6'h20; tick(); irq_in = 0;
        wait_irq(1); ack();
        rd(2, 32'h305, "srv5_status");
        reset = 0; #1;
        chk("arst_irq", 32'(irq), 0);
        chk("arst_id", 32'(int_id), 0);
        rd(1, 0, "arst_mask");
        rd(3, 32'h3F, "arst_edge");
        rd(2, 0, "arst_status");
        reset = 1; tick();

        // stray ack and stray EOI change nothing
        ack(); tick();
        rd(2, 0, "stray_ack_status");
        chk("stray_ack_irq", 32'(irq), 0);
        irq_in = 6'h08; tick(); irq_in = 0;
        wr(2, 0);
        rd(0, 32'h08, "stray_eoi_pending");
        wr(0, 32'h3F);

        // preemption window
        wr(1, 32'h3F);
        id_q.push_back(3);
        irq_in = 6'h08; tick(); irq_in = 0;
        wait_irq(1);
        chk("pre_id3", 32'(int_id), 3);
        irq_in = 6'h01; tick(); irq_in = 0;
        tick();
        chk("pre_irq", 32'(irq), 1);
`ifdef INTC_PREEMPT_EN
        chk("pre_id", 32'(int_id), 0);
        id_q.push_back(3);
`else
        chk("pre_id", 32'(int_id), 3);
        id_q.push_back(0);
`endif
        ack(); wr(2, 0);
        wait_irq(1); ack(); wr(2, 0);
        rd(0, 0, "pre_pending");

        // random rounds: service order is ascending index of pulsed & enabled sources
        for (int k = 0; k < 20; k++) begin
            m = 6'($urandom_range(0, 63));
            s = 6'($urandom_range(1, 63));
            wr(1, 32'(m));
            for (int i = 0; i < 6; i++) if (s[i] & m[i]) id_q.push_back(i);
            irq_in = s; tick(); irq_in = 0;
            for (int i = 0; i < 6; i++) if (s[i] & m[i]) begin
                wait_irq(1); ack(); wr(2, 0);
            end
            tick(4);
            chk("rand_idle_irq", 32'(irq), 0);
            rd(0, 32'(s & ~m), "rand_pending");
            wr(0, 32'h3F);
        end

        tick(2);
        chk("sb_drain", 32'(id_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/intc_ctrl.md
# intc_ctrl

Interrupt controller that sits between the timer blocks (plus other peripherals) and the CPU's hardware interrupt input. It latches up to six interrupt requests into pending bits, masks them, picks the highest-priority pending source, raises a single `irq` to the CPU and holds it through an acknowledge / end-of-interrupt handshake. Software sees a four-word register window on the same `addr[3:2]`/`we`/`Din`/`Dout` bus style the timers use.

## Interface
- `NSRC`, 6: number of interrupt sources; legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `addr`  in  [3:2]  register select.
- `we`  in  1  register write strobe, sampled at `clk` rise.
- `Din`  in  32  write data.
- `Dout`  out  32  read data; combinational from `addr`.
- `irq_in`  in  NSRC  raw requests; bit 0 has the highest priority.
- `int_ack`  in  1  CPU acknowledge; 1-cycle pulse.
- `irq`  out  1  interrupt request to the CPU.
- `int_id`  out  3  index of the source being requested or serviced.

## Operation
- Registers:
  - addr 0 PENDING: read `{0, pending}`; write is write-1-to-clear.
  - addr 1 MASK: read/write `[NSRC-1:0]`; 1 = enabled.
  - addr 2 STATUS: read `{22'b0, state[1:0], 5'b0, int_id}`, with state at bits 9:8. Any write is EOI.
  - addr 3 EDGE: read/write; 1 = rising-edge source, 0 = level source.
- Reset values: pending 0, mask 0, edge all ones, state IDLE, `irq` 0, `int_id` 0, internal `irq_in` history 0.
- Pending update, every cycle, per bit:
  - Edge source: set when `irq_in` = 1 and the previous sample = 0.
  - Level source: pending equals the registered `irq_in`.
  - Clears come from W1C writes and from EOI. If a set and a clear hit the same bit in the same cycle, the set wins.
- FSM: IDLE(00), ARB(01), REQ(10), SRV(11).
  - IDLE: if (pending & mask) ≠ 0, go to ARB.
  - ARB: latch the lowest-index bit of (pending & mask) into `int_id`, go to REQ. If that set is empty by then, return to IDLE.
  - REQ: `irq` = 1.
    - On `int_ack`, go to SRV.
    - If the source at `int_id` is cleared or masked before the ack, drop `irq` and go to IDLE (request withdrawn).
  - SRV: `irq` = 0; wait for EOI.
    - On EOI, clear pending[`int_id`] if it is an edge source, then go to IDLE.
    - Level sources are not cleared by EOI; they re-raise if still high.
- Ignored events: `int_ack` outside REQ, and EOI outside SRV. Neither changes anything.
- Registers can be written in every state. A MASK write takes effect on the next cycle's evaluation.

## Timing
- `irq` and `int_id` are registered outputs.
- Latency: `irq_in` sampled high at edge E0 → pending at E0 → state ARB at E1 → REQ at E2, where `irq` = 1 and `int_id` is valid.
- `irq` falls at the edge that samples `int_ack`.
- After EOI is sampled at edge En, state is IDLE at En. The next request reaches REQ no earlier than En+2.
- An asserted `reset` forces all reset values immediately, mid-handshake included. Release is synchronous to the next `clk` rise.
- Only one interrupt is outstanding at a time; there is no nesting.

## Configuration
- `INTC_PREEMPT_EN` defined:
  - In REQ (before the ack), a newly pending, enabled source with a lower index than `int_id` replaces `int_id` at the next edge.
  - `irq` stays 1 throughout; the ack then applies to the new `int_id`.
- Not defined: `int_id` is frozen from ARB until the ack or the withdrawal.

## Test plan
- Edge latch and handshake:
  - Setup: mask = 0x3F; pulse `irq_in[2]` for 1 cycle.
  - Expect: `irq` = 1 with `int_id` = 2 two cycles after pending sets.
  - `int_ack` → `irq` 0 and STATUS state = 11.
  - EOI → PENDING = 0, state = 00.
- Priority:
  - `irq_in[4]` and `irq_in[1]` rise in the same cycle → `int_id` = 1.
  - After the ack and EOI for source 1 → second request with `int_id` = 4.
- Masking:
  - mask = 0x00, `irq_in[0]` pulses → PENDING = 0x01 and `irq` stays 0.
  - Write mask = 0x01 → `irq` = 1 two cycles later.
  - Write PENDING = 0x01 while in REQ → `irq` drops, state 00.
- Level source:
  - EDGE = 0x3E, `irq_in[0]` held high.
  - After the ack and EOI → a new REQ with `int_id` = 0.
  - Drop `irq_in[0]` → PENDING bit 0 reads 0 the next cycle.
- Reset and stray handshakes:
  - Assert `reset` = 0 during SRV → `irq` = 0, `int_id` = 0, MASK = 0, EDGE = 0x3F.
  - Stray `int_ack` in IDLE → no state change.
- Preempt (`INTC_PREEMPT_EN` only):
  - REQ with `int_id` = 3, then `irq_in[0]` rises before the ack → `int_id` = 0 and `irq` stays 1.
  - Without the macro → `int_id` stays 3.
